// File: rtl/mult_booth_seq.sv
// Sequential signed multiplier, radix-2 Booth, one iteration per clock.
// Checks the even-parity bits of both operands on capture. It then either returns the
// product with its parity bit or flags a parity error.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req               request, sampled only while idle
//   arg_a/arg_b       signed operands with their parity bits
//   ack               one-cycle pulse after operands are captured
//   result*           registered product, parity and error flag, held until next result_rdy
//   result_rdy        one-cycle pulse when result outputs are valid
module mult_booth_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  output logic                  arg_parity_error
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned AccW = 2 * DATA_W + 2;

  typedef enum logic [1:0] {StIdle, StMul, StErr, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_W-1:0]     a_q;
  // Accumulator layout: {P[DATA_W:0], Q[DATA_W-1:0], q_-1}
  logic [AccW-1:0]       acc_q;
  logic                  ack_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  result_parity_q;
  logic                  result_rdy_q;
  logic                  perr_q;

  logic                  perr_in;
  logic [DATA_W:0]       a_ext;
  logic [DATA_W:0]       p_cur;
  logic [DATA_W:0]       p_sum;
  logic signed [AccW-1:0] acc_step;
  logic signed [AccW-1:0] acc_shift;
  logic [2*DATA_W-1:0]   product;

  always_comb begin
    perr_in = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
    a_ext   = {a_q[DATA_W-1], a_q};
    p_cur   = acc_q[AccW-1 -: (DATA_W + 1)];
    case (acc_q[1:0])
      2'b01:   p_sum = p_cur + a_ext;
      2'b10:   p_sum = p_cur - a_ext;
      default: p_sum = p_cur;
    endcase
    acc_step  = {p_sum, acc_q[DATA_W:0]};
    acc_shift = acc_step >>> 1;
    // After the final shift the exact product sits in {P[DATA_W-1:0], Q}.
    product   = acc_shift[2*DATA_W:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      a_q             <= '0;
      acc_q           <= '0;
      ack_q           <= 1'b0;
      result_q        <= '0;
      result_parity_q <= 1'b0;
      result_rdy_q    <= 1'b0;
      perr_q          <= 1'b0;
    end else begin
      ack_q        <= 1'b0;
      result_rdy_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            a_q     <= arg_a;
            acc_q   <= {{(DATA_W + 1){1'b0}}, arg_b, 1'b0};
            cnt_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= perr_in ? StErr : StMul;
          end
        end
        StMul: begin
          acc_q <= acc_shift;
          cnt_q <= cnt_q + 1'b1;
          // Last Booth step: the result is registered on the same edge.
          if (cnt_q == CntW'(DATA_W - 1)) begin
            result_q        <= product;
            result_parity_q <= ^product;
            perr_q          <= 1'b0;
            result_rdy_q    <= 1'b1;
            state_q         <= StDone;
          end
        end
        StErr: begin
          result_q        <= '0;
          result_parity_q <= 1'b0;
          perr_q          <= 1'b1;
          result_rdy_q    <= 1'b1;
          state_q         <= StIdle;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack              = ack_q;
  assign result           = result_q;
  assign result_parity    = result_parity_q;
  assign result_rdy       = result_rdy_q;
  assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
module tb_mult_booth_seq;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [W-1:0]    arg_a;
  logic            arg_a_parity;
  logic [W-1:0]    arg_b;
  logic            arg_b_parity;
  logic            ack;
  logic [2*W-1:0]  result;
  logic            result_parity;
  logic            result_rdy;
  logic            arg_parity_error;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mult_booth_seq #(.DATA_W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model: plain signed arithmetic and parity rules.
  function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  function automatic logic ref_perr(input logic [W-1:0] a, input logic pa,
                                    input logic [W-1:0] b, input logic pb);
    return (pa != ^a) || (pb != ^b);
  endfunction

  // Drives one request and waits (bounded) for result_rdy; returns observations only.
  task automatic run_op(input logic [W-1:0] a, input logic pa, input logic [W-1:0] b,
                        input logic pb, output logic ack_seen, output int lat,
                        output logic [31:0] res, output logic rp, output logic pe);
    arg_a = a; arg_a_parity = pa; arg_b = b; arg_b_parity = pb;
    req = 1'b1;
    tick();
    ack_seen = ack;
    req = 1'b0;
    lat = 1;
    while (result_rdy !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    res = result;
    rp  = result_parity;
    pe  = arg_parity_error;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1;
    arg_a = 16'h0003; arg_a_parity = 1'b0; arg_b = 16'h0003; arg_b_parity = 1'b0;
    tick(); tick();
    n_vec++;
    if ({ack, result_rdy, arg_parity_error, result_parity, result} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b rdy=%b perr=%b rp=%b res=%h, expected all 0",
               ack, result_rdy, arg_parity_error, result_parity, result);
    end
    rst = 1'b0; req = 1'b0;
    tick();
    n_vec++;
    if ({ack, result_rdy, arg_parity_error, result_parity, result} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_idle: got ack=%b rdy=%b perr=%b rp=%b res=%h, expected all 0",
               ack, result_rdy, arg_parity_error, result_parity, result);
    end
  endtask

  logic [W-1:0] da [5] = '{16'h0003, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000};
  logic         dpa[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] db [5] = '{16'hFFFE, 16'h8000, 16'h8000, 16'h0002, 16'h1234};
  logic         dpb[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic test_directed();
    logic ack_seen, rp, pe, exp_pe;
    int lat, exp_lat;
    logic [31:0] res, exp_res;
    for (int i = 0; i < 5; i++) begin
      exp_pe  = ref_perr(da[i], dpa[i], db[i], dpb[i]);
      exp_res = exp_pe ? 32'h0 : ref_prod(da[i], db[i]);
      exp_lat = exp_pe ? 2 : W + 1;
      run_op(da[i], dpa[i], db[i], dpb[i], ack_seen, lat, res, rp, pe);
      n_vec++;
      if (ack_seen !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_ack: got %b expected 1", i, ack_seen);
      end
      n_vec++;
      if (lat != exp_lat) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat);
      end
      n_vec++;
      if (res !== exp_res) begin
        n_err++; $display("FAIL dir%0d_result: got %h expected %h", i, res, exp_res);
      end
      n_vec++;
      if (rp !== ^exp_res) begin
        n_err++; $display("FAIL dir%0d_parity: got %b expected %b", i, rp, ^exp_res);
      end
      n_vec++;
      if (pe !== exp_pe) begin
        n_err++; $display("FAIL dir%0d_perr: got %b expected %b", i, pe, exp_pe);
      end
      tick();
      n_vec++;
      if (result_rdy !== 1'b0 || result !== exp_res || arg_parity_error !== exp_pe) begin
        n_err++;
        $display("FAIL dir%0d_hold: got rdy=%b res=%h perr=%b expected rdy=0 res=%h perr=%b",
                 i, result_rdy, result, arg_parity_error, exp_res, exp_pe);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic pa, pb, ack_seen, rp, pe, exp_pe;
    int lat;
    logic [31:0] res, exp_res;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      pa = (^a) ^ ($urandom_range(0, 5) == 0);
      pb = (^b) ^ ($urandom_range(0, 5) == 0);
      exp_pe  = ref_perr(a, pa, b, pb);
      exp_res = exp_pe ? 32'h0 : ref_prod(a, b);
      run_op(a, pa, b, pb, ack_seen, lat, res, rp, pe);
      n_vec++;
      if (ack_seen !== 1'b1 || lat != (exp_pe ? 2 : W + 1) || res !== exp_res ||
          rp !== ^exp_res || pe !== exp_pe) begin
        n_err++;
        $display("FAIL rand%0d: a=%h b=%h got ack=%b lat=%0d res=%h rp=%b pe=%b expected ack=1 lat=%0d res=%h rp=%b pe=%b",
                 i, a, b, ack_seen, lat, res, rp, pe, exp_pe ? 2 : W + 1, exp_res, ^exp_res,
                 exp_pe);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int rdy_cnt;
    logic ack_seen, rp, pe;
    int lat;
    logic [31:0] res;
    arg_a = 16'h1234; arg_a_parity = 1'b1; arg_b = 16'h0F0F; arg_b_parity = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({ack, result_rdy, arg_parity_error, result_parity, result} !== 36'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: got ack=%b rdy=%b perr=%b rp=%b res=%h, expected all 0",
               ack, result_rdy, arg_parity_error, result_parity, result);
    end
    rdy_cnt = 0;
    repeat (20) begin
      tick();
      if (result_rdy === 1'b1) rdy_cnt++;
    end
    n_vec++;
    if (rdy_cnt != 0) begin
      n_err++; $display("FAIL midreset_no_rdy: got %0d result_rdy pulses expected 0", rdy_cnt);
    end
    run_op(16'h0005, 1'b0, 16'h0005, 1'b0, ack_seen, lat, res, rp, pe);
    n_vec++;
    if (res !== ref_prod(16'h0005, 16'h0005) || lat != W + 1 || pe !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_next_op: got res=%h lat=%0d pe=%b expected res=%h lat=%0d pe=0",
               res, lat, pe, ref_prod(16'h0005, 16'h0005), W + 1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] ca, cb, nb;
    logic [31:0] exp_res;
    int n, last_ack;
    nb = W'($urandom);
    arg_a = 16'h0000; arg_a_parity = 1'b0; arg_b = nb; arg_b_parity = ^nb;
    qa.push_back(16'h0000); qb.push_back(nb);
    req = 1'b1;
    last_ack = -1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (ack !== 1'b1 && n < 40);
      n_vec++;
      if (ack !== 1'b1) begin
        n_err++; $display("FAIL b2b%0d_ack: got %b expected 1", k, ack);
      end
      if (k > 0) begin
        n_vec++;
        if (cyc - last_ack != W + 2) begin
          n_err++;
          $display("FAIL b2b%0d_period: got %0d expected %0d", k, cyc - last_ack, W + 2);
        end
      end
      last_ack = cyc;
      // New operands land mid-operation; they must only affect the next capture.
      nb = W'($urandom);
      arg_a = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
      arg_a_parity = 1'b0;
      arg_b = nb; arg_b_parity = ^nb;
      qa.push_back(arg_a); qb.push_back(nb);
      n = 0;
      while (result_rdy !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      ca = qa.pop_front();
      cb = qb.pop_front();
      exp_res = ref_prod(ca, cb);
      n_vec++;
      if (result_rdy !== 1'b1 || result !== exp_res || arg_parity_error !== 1'b0) begin
        n_err++;
        $display("FAIL b2b%0d_result: a=%h b=%h got rdy=%b res=%h pe=%b expected rdy=1 res=%h pe=0",
                 k, ca, cb, result_rdy, result, arg_parity_error, exp_res);
      end
    end
    req = 1'b0;
    repeat (20) tick();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0;
    arg_a = '0; arg_a_parity = 1'b0; arg_b = '0; arg_b_parity = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
